// File: rtl/sram_pkg.sv
`default_nettype none
// ============================================================================
// Package     : sram_pkg
// Description : Shared state encoding, byte width and byte parity helper for
//               the sram_bank block and its storage array.
// Revision    : 1.0 - initial release
// ============================================================================
package sram_pkg;

   localparam int BYTE_W = 8;

   typedef enum logic [0:0] {
      SB_INIT = 1'b0,
      SB_RUN  = 1'b1
   } sb_state_e;

   // Even parity of one byte (parity of an all-zero byte is 0).
   function automatic logic parity8(input logic [BYTE_W-1:0] b);
      return ^b;
   endfunction

endpackage
`default_nettype wire

// File: rtl/sram_bank_array.sv
`default_nettype none
// ============================================================================
// Module      : sram_bank_array
// Description : Word storage with per-byte-lane writes and a registered read
//               port. Out-of-range writes are dropped and out-of-range reads
//               return zero. With SRAM_BANK_PARITY_EN defined, one even-parity
//               bit per lane is stored and checked on reads.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_bank_array
   import sram_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 1024,
   parameter int ADDR_W = $clog2(DEPTH),
   parameter int NBE    = DATA_W / 8
) (
   input  logic              CLK,
   input  logic              RSTn,
   input  logic              wr_en,
   input  logic [NBE-1:0]    wr_be,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wr_data,
`ifdef SRAM_BANK_PARITY_EN
   input  logic              wr_par_flip,
`endif
   input  logic              rd_en,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_perr
);

   localparam logic [ADDR_W:0] c_depth = (ADDR_W+1)'(DEPTH);

   logic              addr_ok;
   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] rd_data_q, rd_data_d;

   assign addr_ok = ({1'b0, addr} < c_depth);

   // Byte-lane write into the storage array; lanes with be=0 keep their value.
   always_ff @(posedge CLK) begin
      if (wr_en && addr_ok) begin
         for (int b = 0; b < NBE; b++) begin
            if (wr_be[b]) begin
               mem_q[addr][b*BYTE_W +: BYTE_W] <= wr_data[b*BYTE_W +: BYTE_W];
            end
         end
      end
   end

`ifdef SRAM_BANK_PARITY_EN
   logic [NBE-1:0] par_q [DEPTH];
   logic           rd_perr_q, rd_perr_d;

   // Parity bits follow the data lanes; the flip input corrupts them on demand.
   always_ff @(posedge CLK) begin
      if (wr_en && addr_ok) begin
         for (int b = 0; b < NBE; b++) begin
            if (wr_be[b]) begin
               par_q[addr][b] <= parity8(wr_data[b*BYTE_W +: BYTE_W]) ^ wr_par_flip;
            end
         end
      end
   end

   // Next read data and parity flag; both hold until the next read.
   always_comb begin
      rd_data_d = rd_data_q;
      rd_perr_d = rd_perr_q;
      if (rd_en) begin
         rd_data_d = '0;
         rd_perr_d = 1'b0;
         if (addr_ok) begin
            rd_data_d = mem_q[addr];
            for (int b = 0; b < NBE; b++) begin
               if (par_q[addr][b] != parity8(mem_q[addr][b*BYTE_W +: BYTE_W])) begin
                  rd_perr_d = 1'b1;
               end
            end
         end
      end
   end

   // Read register for parity flag.
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) rd_perr_q <= 1'b0;
      else       rd_perr_q <= rd_perr_d;
   end

   assign rd_perr = rd_perr_q;
`else
   // Next read data; holds until the next read.
   always_comb begin
      rd_data_d = rd_data_q;
      if (rd_en) begin
         rd_data_d = addr_ok ? mem_q[addr] : '0;
      end
   end

   assign rd_perr = 1'b0;
`endif

   // Read data register.
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) rd_data_q <= '0;
      else       rd_data_q <= rd_data_d;
   end

   assign rd_data = rd_data_q;

endmodule
`default_nettype wire

// File: rtl/sram_bank.sv
`default_nettype none
// ============================================================================
// Module      : sram_bank
// Description : Single-port synchronous SRAM bank with byte enables, a
//               valid/ready request port and a back-pressurable registered
//               read response. A sequencer zeroes one word per cycle after
//               reset or a soft clear before requests are served.
//               Optional macro SRAM_BANK_PARITY_EN adds per-lane parity and
//               the err_inject test input.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_bank
   import sram_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 1024,
   parameter int ADDR_W = $clog2(DEPTH),
   parameter int NBE    = DATA_W / 8
) (
   input  logic              CLK,
   input  logic              RSTn,
   input  logic              clr,
   output logic              init_done,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [NBE-1:0]    req_be,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
`ifdef SRAM_BANK_PARITY_EN
   input  logic              err_inject,
`endif
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err
);

   localparam logic [ADDR_W:0]   c_depth = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W-1:0] c_last  = ADDR_W'(DEPTH - 1);

   sb_state_e         state_q, state_d;
   logic [ADDR_W-1:0] init_cnt_q, init_cnt_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic              rsp_oor_q, rsp_oor_d;

   logic              arr_we, arr_re, arr_perr;
   logic [NBE-1:0]    arr_be;
   logic [ADDR_W-1:0] arr_addr;
   logic [DATA_W-1:0] arr_wdata, arr_rdata;
   logic              req_addr_ok;
`ifdef SRAM_BANK_PARITY_EN
   logic              arr_flip;
`endif

   assign req_addr_ok = ({1'b0, req_addr} < c_depth);

   // Sweep/run sequencing and steering of the single array port.
   always_comb begin
      state_d    = state_q;
      init_cnt_d = init_cnt_q;
      init_done  = 1'b0;
      req_ready  = 1'b0;
      arr_we     = 1'b0;
      arr_re     = 1'b0;
      arr_be     = '0;
      arr_addr   = req_addr;
      arr_wdata  = req_wdata;
`ifdef SRAM_BANK_PARITY_EN
      arr_flip   = 1'b0;
`endif
      case (state_q)
         SB_INIT: begin
            // One zero word per cycle; clr is ignored until the sweep ends.
            arr_we    = 1'b1;
            arr_be    = '1;
            arr_addr  = init_cnt_q;
            arr_wdata = '0;
            if (init_cnt_q == c_last) begin
               state_d    = SB_RUN;
               init_cnt_d = '0;
            end else begin
               init_cnt_d = init_cnt_q + ADDR_W'(1);
            end
         end
         SB_RUN: begin
            init_done = 1'b1;
            req_ready = !clr && (!rsp_valid_q || rsp_ready);
            if (clr) begin
               state_d    = SB_INIT;
               init_cnt_d = '0;
            end else if (req_valid && req_ready) begin
               if (req_we) begin
                  arr_we = 1'b1;
                  arr_be = req_be;
`ifdef SRAM_BANK_PARITY_EN
                  arr_flip = err_inject;
`endif
               end else begin
                  arr_re = 1'b1;
               end
            end
         end
         default: begin
            state_d    = SB_INIT;
            init_cnt_d = '0;
         end
      endcase
   end

   // Response hold: a new read reloads, otherwise rsp_ready retires the entry.
   always_comb begin
      rsp_valid_d = rsp_valid_q;
      rsp_oor_d   = rsp_oor_q;
      if (arr_re) begin
         rsp_valid_d = 1'b1;
         rsp_oor_d   = !req_addr_ok;
      end else if (rsp_ready) begin
         rsp_valid_d = 1'b0;
      end
   end

   // State, sweep counter and response flags.
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         state_q     <= SB_INIT;
         init_cnt_q  <= '0;
         rsp_valid_q <= 1'b0;
         rsp_oor_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         init_cnt_q  <= init_cnt_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_oor_q   <= rsp_oor_d;
      end
   end

   sram_bank_array #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W),
      .NBE    (NBE)
   ) u_array (
      .CLK         (CLK),
      .RSTn        (RSTn),
      .wr_en       (arr_we),
      .wr_be       (arr_be),
      .addr        (arr_addr),
      .wr_data     (arr_wdata),
`ifdef SRAM_BANK_PARITY_EN
      .wr_par_flip (arr_flip),
`endif
      .rd_en       (arr_re),
      .rd_data     (arr_rdata),
      .rd_perr     (arr_perr)
   );

   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = arr_rdata;
   assign rsp_err   = rsp_oor_q | arr_perr;

endmodule
`default_nettype wire
